// File: rtl/dot_accum_if.sv
// Handshake bundle between the upstream product source, dot_accum and the result consumer.
// The master side drives jobs and products; the slave side is the accumulator.
interface dot_accum_if #(
  parameter int ACC_W = 12
);
  logic             start;
  logic [7:0]       product;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] result;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, product, in_valid, out_ready,
    input  in_ready, result, overflow, out_valid, busy
  );

  modport slave (
    input  start, product, in_valid, out_ready,
    output in_ready, result, overflow, out_valid, busy
  );
endinterface

// File: rtl/dot_accum.sv
// Sums N_TERMS unsigned 8-bit products per job into an ACC_W-bit accumulator
// with a sticky overflow flag, and holds the result until the consumer takes it.
module dot_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input logic         clk,
  input logic         rst_n,
  dot_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] COUNT_LAST = 8'(N_TERMS - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  // One extra bit on the adder so the carry out becomes the overflow flag.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, bus.product};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d   = sum[ACC_W-1:0];
          count_d = count_q + 8'd1;
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
          end
          if (count_q == COUNT_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result is the live accumulator, so it keeps the last job's sum while idle.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = acc_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_dot_accum.sv
// Scoreboard bench for dot_accum: three instances (default, ACC_W=8, N_TERMS=1)
// share product/valid/ready lines but have separate start strobes.
module tb_dot_accum;

  typedef struct {
    int          dut;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] startVec;
  logic [7:0] product;
  logic       inValid;
  logic       outReady;

  int compared;
  int errors;
  exp_t expQ[$];

  logic [2:0]  irW, ovW, busyW, ovfW;
  logic [31:0] resW [3];

  int ivSeq [7] = '{1, 0, 0, 1, 1, 0, 1};
  int pSeq  [7] = '{5, 99, 99, 6, 7, 99, 8};

  dot_accum_if #(.ACC_W(12)) ifA ();
  dot_accum_if #(.ACC_W(8))  ifB ();
  dot_accum_if #(.ACC_W(12)) ifC ();

  dot_accum #(.N_TERMS(4), .ACC_W(12)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave));
  dot_accum #(.N_TERMS(4), .ACC_W(8))  dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.slave));
  dot_accum #(.N_TERMS(1), .ACC_W(12)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC.slave));

  assign ifA.start = startVec[0];
  assign ifB.start = startVec[1];
  assign ifC.start = startVec[2];
  assign ifA.product = product;
  assign ifB.product = product;
  assign ifC.product = product;
  assign ifA.in_valid = inValid;
  assign ifB.in_valid = inValid;
  assign ifC.in_valid = inValid;
  assign ifA.out_ready = outReady;
  assign ifB.out_ready = outReady;
  assign ifC.out_ready = outReady;

  assign irW   = {ifC.in_ready, ifB.in_ready, ifA.in_ready};
  assign ovW   = {ifC.out_valid, ifB.out_valid, ifA.out_valid};
  assign busyW = {ifC.busy, ifB.busy, ifA.busy};
  assign ovfW  = {ifC.overflow, ifB.overflow, ifA.overflow};
  assign resW[0] = 32'(ifA.result);
  assign resW[1] = 32'(ifB.result);
  assign resW[2] = 32'(ifC.result);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      checkOutput({tag, "_in_ready"}, 32'(irW[k]), 32'd0);
      checkOutput({tag, "_out_valid"}, 32'(ovW[k]), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busyW[k]), 32'd0);
      checkOutput({tag, "_result"}, resW[k], 32'd0);
      checkOutput({tag, "_overflow"}, 32'(ovfW[k]), 32'd0);
    end
  endtask

  task automatic startJob(input int d);
    startVec[d] = 1'b1;
    @(posedge clk); #1;
    startVec = '0;
    checkOutput("start_busy", 32'(busyW[d]), 32'd1);
    checkOutput("start_in_ready", 32'(irW[d]), 32'd1);
  endtask

  // One job on consecutive cycles; when outReady is high the handshake edge is consumed too.
  task automatic applyStimulus(input int d, input int n, input int v0, input int v1,
                               input int v2, input int v3, input logic [31:0] expRes,
                               input logic expOvf);
    int vals [4];
    exp_t e;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    e.dut = d; e.res = expRes; e.ovf = expOvf;
    expQ.push_back(e);
    startJob(d);
    for (int i = 0; i < n; i++) begin
      product = 8'(vals[i]);
      inValid = 1'b1;
      @(posedge clk); #1;
      if (i == n - 2) checkOutput("early_out_valid", 32'(ovW[d]), 32'd0);
    end
    inValid = 1'b0;
    checkOutput("latency_out_valid", 32'(ovW[d]), 32'd1);
    if (outReady) begin
      @(posedge clk); #1;
      checkOutput("after_ack_busy", 32'(busyW[d]), 32'd0);
      checkOutput("after_ack_result_kept", resW[d], expRes);
    end
  endtask

  // Scoreboard monitor: pops on the first out_valid cycle, then checks stability while held.
  initial begin
    logic [2:0]  presenting;
    logic [31:0] heldRes [3];
    logic        heldOvf [3];
    exp_t e;
    presenting = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (ovW[k]) begin
          if (!presenting[k]) begin
            if (expQ.size() == 0) begin
              compared++;
              errors++;
              $display("[TB] FAIL unexpected_out_valid: dut %0d result %0d, expected no output", k, resW[k]);
            end else begin
              e = expQ.pop_front();
              checkOutput("sb_dut", 32'(k), 32'(e.dut));
              checkOutput("sb_result", resW[k], e.res);
              checkOutput("sb_overflow", 32'(ovfW[k]), 32'(e.ovf));
              heldRes[k] = e.res;
              heldOvf[k] = e.ovf;
            end
            presenting[k] = 1'b1;
          end else begin
            checkOutput("stable_result", resW[k], heldRes[k]);
            checkOutput("stable_overflow", 32'(ovfW[k]), 32'(heldOvf[k]));
          end
          if (outReady) presenting[k] = 1'b0;
        end else begin
          presenting[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared = 0;
    errors   = 0;
    startVec = '0;
    product  = '0;
    inValid  = 1'b0;
    outReady = 1'b1;
    rst_n    = 1'b0;

    // Reset state, during and one cycle after reset.
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkIdleOutputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkIdleOutputs("after_reset");

    // Products offered while idle must be ignored.
    product = 8'd50;
    inValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("idle_ignore_busy", 32'(busyW), 32'd0);
    checkOutput("idle_ignore_result", resW[0], 32'd0);

    // Basic job, then back-to-back job of maximum products.
    applyStimulus(0, 4, 10, 20, 30, 40, 32'd100, 1'b0);
    outReady = 1'b0;
    applyStimulus(0, 4, 225, 225, 225, 225, 32'd900, 1'b0);
    startVec[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      startVec = '0;
      checkOutput("hold_out_valid", 32'(ovW[0]), 32'd1);
      checkOutput("hold_result", resW[0], 32'd900);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold_release_busy", 32'(busyW[0]), 32'd0);

    // 8-bit accumulator wrap with sticky overflow, then overflow cleared by the next start.
    applyStimulus(1, 4, 200, 100, 0, 1, 32'd45, 1'b1);
    applyStimulus(1, 4, 1, 1, 1, 1, 32'd4, 1'b0);

    // Gapped valid with start pulses inside ACCUM.
    begin
      exp_t e;
      e.dut = 0; e.res = 32'd26; e.ovf = 1'b0;
      expQ.push_back(e);
    end
    startJob(0);
    for (int i = 0; i < 7; i++) begin
      product = 8'(pSeq[i]);
      inValid = (ivSeq[i] != 0);
      startVec[0] = (ivSeq[i] == 0);
      @(posedge clk); #1;
      if (i == 5) checkOutput("gap_not_done", 32'(ovW[0]), 32'd0);
    end
    inValid = 1'b0;
    startVec = '0;
    checkOutput("gap_done", 32'(ovW[0]), 32'd1);
    @(posedge clk); #1;
    checkOutput("gap_ack_busy", 32'(busyW[0]), 32'd0);

    // Reset mid-job, asserted together with start and valid.
    startJob(0);
    product = 8'd11; inValid = 1'b1;
    @(posedge clk); #1;
    product = 8'd22;
    @(posedge clk); #1;
    checkOutput("midjob_partial", resW[0], 32'd33);
    rst_n = 1'b0;
    startVec[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    startVec = '0;
    inValid = 1'b0;
    checkOutput("midjob_reset_busy", 32'(busyW[0]), 32'd0);
    checkOutput("midjob_reset_result", resW[0], 32'd0);
    checkOutput("midjob_reset_in_ready", 32'(irW[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midjob_no_output", 32'(ovW[0]), 32'd0);
    applyStimulus(0, 4, 1, 2, 3, 4, 32'd10, 1'b0);

    // Single-term instance finishes on its only product.
    applyStimulus(2, 1, 77, 0, 0, 0, 32'd77, 1'b0);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/dot_accum.md
DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 4, giving the number of products summed per job (legal range 1..255).
REQ-002 The block SHALL have parameter ACC_W, default 12, giving the accumulator and result width in bits (legal range 8..32).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin a new job; sampled only in IDLE.
REQ-006 product  input  8  unsigned 8-bit product from the upstream 4x4 unsigned multiplier.
REQ-007 in_valid  input  1  product is valid this cycle.
REQ-008 in_ready  output  1  block accepts product this cycle.
REQ-009 result  output  ACC_W  accumulated sum of the job's products.
REQ-010 overflow  output  1  sticky flag: the job's sum exceeded 2^ACC_W-1.
REQ-011 out_valid  output  1  result and overflow are valid.
REQ-012 out_ready  input  1  downstream consumes result this cycle.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-015 In IDLE, the block SHALL transition to ACCUM when start=1; on that edge, acc, count and overflow SHALL be cleared to 0.
REQ-016 A product SHALL be accepted on a rising edge only when state=ACCUM, in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL equal 1 exactly when state=ACCUM; it SHALL be combinational from state only, with no dependence on in_valid.
REQ-018 On each acceptance:
- acc SHALL become (acc + product) mod 2^ACC_W.
- count SHALL increment by 1.
- overflow SHALL be set if the ACC_W+1-bit sum has its MSB set; it SHALL stay set until the next start or reset.
REQ-019 When the accepted product is number N_TERMS (count = N_TERMS-1 before the edge), the block SHALL go to DONE on that same edge.
REQ-020 Latency: out_valid SHALL rise in the cycle immediately after the final product is accepted.
REQ-021 In DONE, out_valid SHALL be 1 and result SHALL equal acc; result and overflow SHALL stay stable until handshake completion.
REQ-022 On out_valid=1 and out_ready=1, the block SHALL return to IDLE; result SHALL keep its last value in IDLE until the next start.
REQ-023 in_valid while not in ACCUM SHALL be ignored: no state change and no acceptance.
REQ-024 start while in ACCUM or DONE SHALL be ignored.
REQ-025 In ACCUM with in_valid=0, acc and count SHALL hold; there is no timeout.
REQ-026 Back-to-back jobs: start asserted in the first IDLE cycle after the DONE handshake SHALL begin a new job, giving one idle cycle minimum between jobs.
REQ-027 With N_TERMS=1, a single accepted product SHALL move the block directly to DONE.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL return to IDLE from any state.
REQ-029 Reset SHALL clear acc, count and overflow to 0.
REQ-030 Output values while in reset, and on the cycle after it: in_ready=0, out_valid=0, busy=0, result=0, overflow=0.
REQ-031 Reset mid-job SHALL discard the partial sum; no out_valid SHALL follow for that job.
REQ-032 Reset SHALL take priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-033 Default parameters; start, then products 10, 20, 30, 40 on consecutive cycles -> out_valid one cycle after 40 is accepted, result=100, overflow=0.
REQ-034 Default parameters; four products of 225 (15x15) -> result=900, overflow=0; then hold out_ready=0 for 5 cycles -> result stays 900 and out_valid stays 1 throughout.
REQ-035 ACC_W=8; products 200, 100, 0, 1 -> result=45 ((301) mod 256), overflow=1; next job with products 1, 1, 1, 1 -> result=4, overflow=0.
REQ-036 in_valid toggled 1,0,0,1,1,0,1 with products 5,x,x,6,7,x,8 -> exactly 4 acceptances, result=26; start pulses during ACCUM have no effect.
REQ-037 rst_n=0 for one cycle after 2 products accepted -> IDLE, result=0, busy=0; new job with 1, 2, 3, 4 -> result=10.
REQ-038 N_TERMS=1; start, then product 77 -> DONE next cycle with result=77; out_ready held at 1 -> IDLE after one out_valid cycle.
